serv_mdu_seq: RTL and testbench

SERV_MDU_SEQ -- requirements
Module: serv_mdu_seq

---
 rtl/serv_mdu_seq_pkg.sv | 34 +++
 rtl/serv_mdu_step.sv | 35 +++
 rtl/serv_mdu_seq.sv | 154 +++++++++++++++
 tb/tb_serv_mdu_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serv_mdu_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit: funct3 opcodes,
// FSM states and operand-signedness decode, reusable by the core decoder and benches.
package serv_mdu_seq_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BUSY = 3'd1,
        ST_FIX  = 3'd2,
        ST_DONE = 3'd3,
        ST_HOLD = 3'd4
    } mdu_state_e;

    // MUL only needs the low word, which is sign-agnostic, so it runs unsigned.
    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/serv_mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift for divide,
// both sharing a single 33-bit adder/subtractor.
module serv_mdu_step
    import serv_mdu_seq_pkg::*;
(
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] op_a;
    logic [33:0] op_b;
    logic [33:0] sum;
    logic        div_ge;
    logic [32:0] mul_hi;

    // Divide: {remainder, next dividend bit}; multiply: upper product half.
    assign op_a = is_div_i ? acc_i[63:31] : {1'b0, acc_i[63:32]};
    assign op_b = is_div_i ? ~{2'b00, opnd_i} : {2'b00, opnd_i};
    assign sum  = {1'b0, op_a} + op_b + {33'd0, is_div_i};

    // A negative difference shows up in bit 33 of the two's-complement result.
    assign div_ge = ~sum[33];
    assign mul_hi = acc_i[0] ? sum[32:0] : {1'b0, acc_i[63:32]};

    always_comb begin
        if (is_div_i) begin
            acc_o = {(div_ge ? sum[31:0] : acc_i[62:31]), acc_i[30:0], div_ge};
        end else begin
            acc_o = {mul_hi, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/serv_mdu_seq.sv
// Sequential RV32M multiply/divide unit: 32 radix-2 iterations on magnitudes,
// then a sign-fix cycle, a one-cycle ready pulse and a one-cycle hold-off.
module serv_mdu_seq
    import serv_mdu_seq_pkg::*;
#(
    parameter int DIV_SHORTCUT = 1
)
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_mdu_valid,
    input  logic [31:0] i_mdu_rs1,
    input  logic [31:0] i_mdu_rs2,
    input  logic [2:0]  i_mdu_funct3,
    output logic [31:0] o_mdu_rd,
    output logic        o_mdu_ready
);

    mdu_state_e  state_q;
    logic [4:0]  cnt_q;
    logic        ready_q;
    logic [31:0] rd_q;

    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic [2:0]  f3_q;
    logic        neg_a_q;
    logic        neg_b_q;
    logic        div_zero_q;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        is_div;
    logic        div_zero;
    logic        div_ovf;
    logic        shortcut;
    logic [63:0] acc_d;
    logic [31:0] opnd_d;
    logic        accept;

    logic [63:0] step_acc;
    logic        neg_res;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] result;

    assign accept = (state_q == ST_IDLE) && i_mdu_valid;

    always_comb begin
        a_neg    = rs1_is_signed(i_mdu_funct3) & i_mdu_rs1[31];
        b_neg    = rs2_is_signed(i_mdu_funct3) & i_mdu_rs2[31];
        a_abs    = a_neg ? (~i_mdu_rs1 + 32'd1) : i_mdu_rs1;
        b_abs    = b_neg ? (~i_mdu_rs2 + 32'd1) : i_mdu_rs2;
        is_div   = i_mdu_funct3[2];
        div_zero = is_div && (i_mdu_rs2 == 32'd0);
        div_ovf  = is_div && !i_mdu_funct3[0] && (i_mdu_rs1 == INT_MIN) && (i_mdu_rs2 == ALL_ONE);
        shortcut = (DIV_SHORTCUT != 0) && (div_zero || div_ovf);

        // Shortcuts preload the accumulator so the normal sign-fix yields the final answer.
        acc_d  = {32'd0, a_abs};
        opnd_d = b_abs;
        if (!is_div) begin
            acc_d  = {32'd0, b_abs};
            opnd_d = a_abs;
        end else if (shortcut && div_zero) begin
            acc_d = {a_abs, ALL_ONE};
        end else if (shortcut) begin
            acc_d = {32'd0, INT_MIN};
        end
    end

    serv_mdu_step u_step (
        .is_div_i (f3_q[2]),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        neg_res  = neg_a_q ^ neg_b_q;
        prod_fix = neg_res ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = div_zero_q ? ALL_ONE : (neg_res ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
        rem_fix  = neg_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        case (f3_q)
            F3_MUL:                       result = prod_fix[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[63:32];
            F3_DIV, F3_DIVU:              result = quo_fix;
            default:                      result = rem_fix;
        endcase
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            f3_q       <= i_mdu_funct3;
            neg_a_q    <= a_neg;
            neg_b_q    <= b_neg;
            div_zero_q <= div_zero;
        end else if (state_q == ST_BUSY) begin
            acc_q <= step_acc;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            ready_q <= 1'b0;
            rd_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (i_mdu_valid) begin
                        cnt_q   <= 5'd0;
                        state_q <= shortcut ? ST_FIX : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    rd_q    <= result;
                    ready_q <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    ready_q <= 1'b0;
                    state_q <= ST_HOLD;
                end
                // One dead cycle so a valid that lingers after ready is not re-accepted.
                ST_HOLD: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mdu_rd    = rd_q;
    assign o_mdu_ready = ready_q;

endmodule

// File: tb/tb_serv_mdu_seq.sv
// Directed bench: two instances (with and without the divide shortcut) see the same
// stimulus; result, ready latency and pulse count are checked against hand-computed values.
module tb_serv_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rd_sc;
    logic        rdy_sc;
    logic [31:0] rd_ns;
    logic        rdy_ns;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serv_mdu_seq #(.DIV_SHORTCUT(1)) u_dut_sc (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_mdu_valid  (valid),
        .i_mdu_rs1    (rs1),
        .i_mdu_rs2    (rs2),
        .i_mdu_funct3 (funct3),
        .o_mdu_rd     (rd_sc),
        .o_mdu_ready  (rdy_sc)
    );

    serv_mdu_seq #(.DIV_SHORTCUT(0)) u_dut_ns (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_mdu_valid  (valid),
        .i_mdu_rs1    (rs1),
        .i_mdu_rs2    (rs2),
        .i_mdu_funct3 (funct3),
        .o_mdu_rd     (rd_ns),
        .o_mdu_ready  (rdy_ns)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: drop valid on first ready; 1: drop right after acceptance;
    // 2: keep valid through the two edges after the ready pulse.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd,
                          input int lat_sc, input int mode);
        int lat_s = -1;
        int lat_n = -1;
        int pul_s = 0;
        int pul_n = 0;
        @(posedge clk);
        #1;
        valid  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                rs1    = $urandom;
                rs2    = $urandom;
                funct3 = 3'($urandom);
                if (mode == 1) valid = 1'b0;
            end
            if (rdy_sc) begin
                pul_s++;
                if (lat_s < 0) lat_s = k;
            end
            if (rdy_ns) begin
                pul_n++;
                if (lat_n < 0) lat_n = k;
            end
            if (mode == 0 && (rdy_sc || rdy_ns)) valid = 1'b0;
            if (mode == 2 && k == lat_sc + 2) valid = 1'b0;
        end
        valid = 1'b0;
        $display("[TB] %s f3=%0d a=%h b=%h rd_sc=%h lat_sc=%0d rd_ns=%h lat_ns=%0d",
                 tag, f3, a, b, rd_sc, lat_s, rd_ns, lat_n);
        check_eq({tag, " rd_sc"}, rd_sc, exp_rd);
        check_eq({tag, " rd_ns"}, rd_ns, exp_rd);
        check_eq({tag, " lat_sc"}, 32'(lat_s), 32'(lat_sc));
        check_eq({tag, " lat_ns"}, 32'(lat_n), 32'd33);
        check_eq({tag, " pulses_sc"}, 32'(pul_s), 32'd1);
        check_eq({tag, " pulses_ns"}, 32'(pul_n), 32'd1);
    endtask

    task automatic reset_mid_op();
        int pul = 0;
        @(posedge clk);
        #1;
        valid  = 1'b1;
        funct3 = 3'b000;
        rs1    = 32'h0000_1234;
        rs2    = 32'h0000_0101;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) valid = 1'b0;
            if (rdy_sc || rdy_ns) pul++;
        end
        rst_n = 1'b0;
        #2;
        $display("[TB] reset mid-op rd_sc=%h rdy_sc=%b rd_ns=%h rdy_ns=%b", rd_sc, rdy_sc, rd_ns, rdy_ns);
        check_eq("rst_mid rd_sc", rd_sc, 32'd0);
        check_eq("rst_mid rd_ns", rd_ns, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy_sc || rdy_ns) pul++;
        end
        check_eq("rst_mid no_ready", 32'(pul), 32'd0);
        check_eq("rst_mid rd_hold", rd_sc, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        $display("[TB] reset rd_sc=%h rdy_sc=%b rd_ns=%h rdy_ns=%b", rd_sc, rdy_sc, rd_ns, rdy_ns);
        check_eq("reset rd_sc", rd_sc, 32'd0);
        check_eq("reset rdy_sc", 32'(rdy_sc), 32'd0);
        check_eq("reset rd_ns", rd_ns, 32'd0);
        check_eq("reset rdy_ns", 32'(rdy_ns), 32'd0);
        #20;
        rst_n = 1'b1;

        run_op("MUL_7x6",      3'b000, 32'd7,         32'd6,         32'h0000_002A, 33, 0);
        run_op("MUL_neg",      3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33, 1);
        run_op("MULH_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        run_op("MULH_m1x2",    3'b001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 0);
        run_op("MULHU_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        run_op("MULHSU_max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        run_op("DIV_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
        run_op("REM_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
        run_op("DIV_min_2",    3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, 33, 1);
        run_op("DIVU_100_7",   3'b101, 32'd100,       32'd7,         32'd14,        33, 0);
        run_op("REMU_100_7",   3'b111, 32'd100,       32'd7,         32'd2,         33, 0);
        run_op("DIVU_5_0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
        run_op("REMU_5_0",     3'b111, 32'd5,         32'd0,         32'd5,         1,  0);
        run_op("DIV_m5_0",     3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1,  0);
        run_op("REM_m5_0",     3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  0);
        run_op("DIV_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        run_op("REM_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);
        run_op("MUL_linger",   3'b000, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 33, 2);
        reset_mid_op();
        run_op("MUL_3x3",      3'b000, 32'd3,         32'd3,         32'd9,         33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
